// File: rtl/if_fetch_ctrl_pkg.sv
// if_fetch_ctrl_pkg
//   Definitions shared by the pipeline-stage controllers: the run/halt state
//   encoding, the NOP word, and the location of the ROM word index inside a
//   byte address.
package if_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // The ROM is 64 words, and it is indexed by byte-address bits [7:2].
  localparam int ROM_IDX_HI = 7;
  localparam int ROM_IDX_LO = 2;
  localparam int ROM_IDX_W  = ROM_IDX_HI - ROM_IDX_LO + 1;

  // Returns the ROM word index from the low byte of an address.
  function automatic logic [ROM_IDX_W-1:0] rom_idx(input logic [7:0] addr_lo);
    return addr_lo[ROM_IDX_HI:ROM_IDX_LO];
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_ifid_reg.sv
// if_fetch_ctrl_ifid_reg
//   IF/ID pipeline register. It has a hold input and a clear input.
//   Priority, highest first: rst, flush, hold, load.
//   When it loads, valid is set and pc4 is computed from d_pc.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   hold            keep the current contents
//   flush           clear the contents to a bubble (all zero)
//   d_inst, d_pc    instruction and its address to capture
//   valid, inst, pc, pc4  registered IF/ID contents
module if_fetch_ctrl_ifid_reg
  import if_fetch_ctrl_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic [INST_W-1:0] d_inst,
  input  logic [PC_W-1:0]   d_pc,
  output logic              valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc4
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
      inst  <= INST_W'(NOP_INST);
      pc    <= '0;
      pc4   <= '0;
    end else if (!hold) begin
      valid <= 1'b1;
      inst  <= d_inst;
      pc    <= d_pc;
      pc4   <= d_pc + PC_W'(4);
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl
//   Instruction-fetch sequencer. It owns the PC and drives the ROM address.
//   It loads IF/ID from the combinational ROM data.
//   A run/halt FSM starts fetching on a start pulse. It stops after the
//   word at ROM index LAST_IDX has been latched.
//   In RUN, the priority is: redirect (flush), then stall (hold), then fetch.
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   start                       pulse that leaves IDLE
//   stall                       hazard hold for the PC, IF/ID and the counter
//   redirect_valid/redirect_pc  taken branch/jump target (it is word-aligned here)
//   rom_addr / rom_inst         ROM address (the pc register) and its data
//   ifid_valid/inst/pc/pc4      IF/ID register outputs
//   halted                      registered flag that shows the FSM is in HALT
//   fetch_cnt                   saturating count of valid instructions latched
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int                     PC_W     = 32,
  parameter logic [PC_W-1:0]        RESET_PC = '0,
  parameter logic [ROM_IDX_W-1:0]   LAST_IDX = 6'h3F,
  parameter int                     CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic [PC_W-1:0]  rom_addr,
  input  logic [31:0]      rom_inst,
  output logic             ifid_valid,
  output logic [31:0]      ifid_inst,
  output logic [PC_W-1:0]  ifid_pc,
  output logic [PC_W-1:0]  ifid_pc4,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt
);

  fetch_state_e    state;
  logic [PC_W-1:0] pc;

  logic in_run, advance, flush, at_last;

  assign in_run  = (state == ST_RUN);
  // A normal fetch happens only in RUN, with no redirect and no stall.
  assign advance = in_run && !redirect_valid && !stall;
  // A redirect makes a one-cycle bubble. Every HALT cycle keeps IF/ID clear,
  // so the last instruction is dropped on the first HALT edge.
  assign flush   = (in_run && redirect_valid) || (state == ST_HALT);
  assign at_last = (rom_idx(pc[7:0]) == LAST_IDX);

  assign rom_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      fetch_cnt <= '0;
      halted    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_RUN;
        end
        ST_RUN: begin
          if (redirect_valid) begin
            pc <= {redirect_pc[PC_W-1:2], 2'b00};
          end else if (!stall) begin
            if (fetch_cnt != '1) fetch_cnt <= fetch_cnt + 1'b1;
            // The last word is latched normally, and the pc stays on it.
            if (at_last) state <= ST_HALT;
            else         pc    <= pc + PC_W'(4);
          end
        end
        ST_HALT: begin
          // Set on the first HALT edge, at the same edge where IF/ID clears.
          halted <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  if_fetch_ctrl_ifid_reg #(.PC_W(PC_W), .INST_W(32)) u_ifid (
    .clk    (clk),
    .rst    (rst),
    .hold   (!advance),
    .flush  (flush),
    .d_inst (rom_inst),
    .d_pc   (pc),
    .valid  (ifid_valid),
    .inst   (ifid_inst),
    .pc     (ifid_pc),
    .pc4    (ifid_pc4)
  );

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch sequencer for the pipelined datapath. It owns the program counter, drives the instruction ROM address, and loads the IF/ID pipeline register. It obeys stall requests from the data-hazard unit and redirect (branch/jump) requests from later stages. A small run/halt state machine starts fetch on command and stops cleanly at the top of program memory.

## Interface
- PC_W, 32, program-counter and address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word 0 holds a NOP)
- LAST_IDX, 6'h3F, ROM word index of the last fetchable instruction (ROM is 64 words, indexed by address bits [7:2])
- CNT_W, 16, width of the fetch counter
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; leaves IDLE
- stall  in  1  hazard-unit hold request for PC and IF/ID
- redirect_valid  in  1  branch/jump taken, qualifies redirect_pc
- redirect_pc  in  PC_W  target address
- rom_addr  out  PC_W  address to instruction ROM (equals pc register)
- rom_inst  in  32  combinational ROM data for rom_addr
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_inst  out  32  latched instruction
- ifid_pc  out  PC_W  address of ifid_inst
- ifid_pc4  out  PC_W  ifid_pc + 4
- halted  out  1  state is HALT
- fetch_cnt  out  CNT_W  count of instructions latched with valid=1, saturating

## Operation
- States: IDLE, RUN, HALT. Reset enters IDLE.
- IDLE:
  - PC holds RESET_PC; ifid_valid=0.
  - start → RUN. stall and redirect are ignored.
- RUN, evaluated once per cycle, highest priority first:
  1. redirect_valid: pc ← {redirect_pc[PC_W-1:2],2'b00}. IF/ID flushed: valid=0, inst=0, pc/pc4=0. Overrides stall and the halt check.
  2. stall: pc, IF/ID and fetch_cnt all hold.
  3. Otherwise: IF/ID ← {1, rom_inst, pc, pc+4}; pc ← pc+4; fetch_cnt += 1, saturating at all-ones.
- Halt check, applied in the case-3 cycle: if pc[7:2]==LAST_IDX, the instruction is latched normally, the next state is HALT, and pc is not incremented.
- HALT:
  - ifid_valid drops to 0 on the first HALT cycle; inst, pc and pc4 are cleared.
  - pc and fetch_cnt are frozen.
  - start, stall and redirect are ignored; only rst exits.
- start while in RUN or HALT is ignored.
- PC arithmetic is modulo 2^PC_W. rom_addr is the full pc; the ROM decodes bits [7:2].
- A NOP word (32'h0) is fetched and counted like any other instruction.

## Timing
- Reset values:
  - pc=RESET_PC, state=IDLE.
  - ifid_valid=0, ifid_inst=0, ifid_pc=0, ifid_pc4=0.
  - halted=0, fetch_cnt=0.
- rom_addr is a register output; the ROM returns data in the same cycle; IF/ID captures it at the next edge. Fetch latency is 1 cycle from PC to IF/ID.
- start sampled at edge N → RUN from N. The first fetch (word at RESET_PC) appears in IF/ID after edge N+1.
- Redirect sampled at edge N → IF/ID bubble after N. The target instruction is in IF/ID after N+1. Redirect penalty is 1 bubble.
- Stall held for k cycles → IF/ID and pc unchanged for exactly k edges. Fetch resumes on the first edge with stall=0.
- Simultaneous stall and redirect → redirect wins.
- halted rises on the edge after the LAST_IDX fetch, in the same edge where ifid_valid falls.
- rst asserted mid-RUN or in HALT → all reset values at the next edge, regardless of other inputs.

## Structure
- Shared package holds:
  - state encoding: ST_IDLE=2'd0, ST_RUN=2'd1, ST_HALT=2'd2
  - NOP constant 32'h0000_0000
  - ROM index field constants (bits 7:2)
- Other pipeline-stage controllers reuse the package.
- One sub-module is natural: ifid_reg, the IF/ID pipeline register with hold (stall) and clear (flush) inputs. The decode side instantiates the same register pattern.
- The FSM, PC and counter stay in the top.

## Test plan
- Reset then start at cycle 2, ROM words 1..6 loaded: IF/ID shows pc 0,4,8,…,0x18 on consecutive cycles; fetch_cnt reaches 7 after word 6.
- Stall high for 3 cycles while IF/ID holds pc=0x08: pc stays 0x0C, IF/ID stays 0x08 for 3 edges; the next edge latches 0x0C.
- redirect_valid with redirect_pc=0x15 while pc=0x10: the next IF/ID has valid=0, and pc becomes 0x14; the following edge latches the word at 0x14 with ifid_pc=0x14.
- stall and redirect (target 0x20) in the same cycle: redirect taken, bubble inserted, pc=0x20.
- Run from RESET_PC with no redirects: the word at 0xFC is latched, then halted=1 and ifid_valid=0; start and redirect over the next 10 cycles change nothing; fetch_cnt=64.
- rst pulsed while in RUN at pc=0x18: the next cycle shows IDLE, pc=0, all IF/ID fields 0, fetch_cnt=0; start resumes from word 0.
